// File: rtl/mips_defs.sv
// Shared MIPS pipeline definitions: next-PC selector encoding and the reset PC.
package mips_defs;

  typedef enum logic [1:0] {
    NPC_PC4 = 2'd0,
    NPC_BR  = 2'd1,
    NPC_J   = 2'd2,
    NPC_JR  = 2'd3
  } npc_sel_e;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  // Branch displacement: sign-extended 16-bit word offset turned into a byte offset.
  function automatic logic [31:0] br_offset(input logic [15:0] imm16);
    br_offset = {{14{imm16[15]}}, imm16, 2'b00};
  endfunction

endpackage

// File: rtl/f_npc_calc.sv
// Next-PC calculator: chooses between sequential fetch and the redirect resolved in D.
module f_npc_calc
  import mips_defs::*;
(
  input  logic [31:0] pc,
  input  logic [1:0]  npc_sel,
  input  logic        br_taken,
  input  logic [31:0] d_pc,
  input  logic [15:0] d_imm16,
  input  logic [25:0] d_imm26,
  input  logic [31:0] d_rs_fwd,
  output logic [31:0] npc
);

  logic [31:0] pc_plus4;
  logic [31:0] br_target;

  assign pc_plus4  = pc + 32'd4;
  // Branch target is relative to the delay slot, i.e. the branch PC plus 4.
  assign br_target = d_pc + 32'd4 + br_offset(d_imm16);

  // Select the next PC; a not-taken branch falls through sequentially.
  always_comb begin
    npc = pc_plus4;
    case (npc_sel_e'(npc_sel))
      NPC_PC4: npc = pc_plus4;
      NPC_BR: begin
        if (br_taken) begin
          npc = br_target;
        end else begin
          npc = pc_plus4;
        end
      end
      NPC_J:   npc = {d_pc[31:28], d_imm26, 2'b00};
      NPC_JR:  npc = d_rs_fwd;
      default: npc = pc_plus4;
    endcase
  end

endmodule

// File: rtl/f_fetch_unit.sv
// Fetch stage: PC register, instruction-memory address, address-error check, fetch counter.
module f_fetch_unit
  import mips_defs::*;
#(
  parameter logic [31:0] RESET_PC = mips_defs::RESET_PC,
  parameter int unsigned IM_BYTES = 16384
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        f_en,
  input  logic [1:0]  npc_sel,
  input  logic        br_taken,
  input  logic [31:0] d_pc,
  input  logic [15:0] d_imm16,
  input  logic [25:0] d_imm26,
  input  logic [31:0] d_rs_fwd,
  output logic [31:0] i_inst_addr,
  input  logic [31:0] i_inst_rdata,
  output logic [31:0] F_PC,
  output logic [31:0] F_instr,
  output logic        F_exc_adel,
  output logic [31:0] fetch_cnt
);

  // Upper bound kept 33 bits wide so RESET_PC+IM_BYTES cannot overflow.
  localparam logic [32:0] PC_LIMIT = {1'b0, RESET_PC} + 33'(IM_BYTES);

  logic [31:0] pc_r;
  logic [31:0] fetch_cnt_r;
  logic [31:0] npc_s;
  logic        adel_s;

  f_npc_calc u_npc_calc (
    .pc       (pc_r),
    .npc_sel  (npc_sel),
    .br_taken (br_taken),
    .d_pc     (d_pc),
    .d_imm16  (d_imm16),
    .d_imm26  (d_imm26),
    .d_rs_fwd (d_rs_fwd),
    .npc      (npc_s)
  );

  // PC register: reset wins, then stall holds (dropping any redirect), else advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_r <= RESET_PC;
    end else if (f_en) begin
      pc_r <= npc_s;
    end else begin
      pc_r <= pc_r;
    end
  end

  // Accepted-fetch counter; wraps naturally and counts erroneous fetches too.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt_r <= 32'd0;
    end else if (f_en) begin
      fetch_cnt_r <= fetch_cnt_r + 32'd1;
    end else begin
      fetch_cnt_r <= fetch_cnt_r;
    end
  end

  // Address error: misaligned or outside the instruction memory window.
  always_comb begin
    adel_s = 1'b0;
    if (pc_r[1:0] != 2'b00) begin
      adel_s = 1'b1;
    end else if (pc_r < RESET_PC) begin
      adel_s = 1'b1;
    end else if ({1'b0, pc_r} >= PC_LIMIT) begin
      adel_s = 1'b1;
    end else begin
      adel_s = 1'b0;
    end
  end

  assign i_inst_addr = pc_r;
  assign F_PC        = pc_r;
  assign F_exc_adel  = adel_s;
  assign F_instr     = adel_s ? 32'h0000_0000 : i_inst_rdata;
  assign fetch_cnt   = fetch_cnt_r;

endmodule

// File: tb/tb_f_fetch_unit.sv
// Directed-vector bench for the fetch stage.
module tb_f_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        f_en;
  logic [1:0]  npc_sel;
  logic        br_taken;
  logic [31:0] d_pc;
  logic [15:0] d_imm16;
  logic [25:0] d_imm26;
  logic [31:0] d_rs_fwd;
  logic [31:0] i_inst_addr;
  logic [31:0] i_inst_rdata;
  logic [31:0] F_PC;
  logic [31:0] F_instr;
  logic        F_exc_adel;
  logic [31:0] fetch_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Instruction memory stand-in: data is a fixed scramble of the address.
  assign i_inst_rdata = i_inst_addr ^ 32'hDEAD_0000;

  f_fetch_unit dut (
    .clk          (clk),
    .reset        (reset),
    .f_en         (f_en),
    .npc_sel      (npc_sel),
    .br_taken     (br_taken),
    .d_pc         (d_pc),
    .d_imm16      (d_imm16),
    .d_imm26      (d_imm26),
    .d_rs_fwd     (d_rs_fwd),
    .i_inst_addr  (i_inst_addr),
    .i_inst_rdata (i_inst_rdata),
    .F_PC         (F_PC),
    .F_instr      (F_instr),
    .F_exc_adel   (F_exc_adel),
    .fetch_cnt    (fetch_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Full-state check against hand-computed PC, error flag and count.
  task automatic chk_state(input string tag, input logic [31:0] pc, input logic adel,
                           input logic [31:0] cnt);
    chk({tag, ".pc"},   F_PC, pc);
    chk({tag, ".addr"}, i_inst_addr, pc);
    chk({tag, ".adel"}, {31'd0, F_exc_adel}, {31'd0, adel});
    chk({tag, ".instr"}, F_instr, adel ? 32'h0 : (pc ^ 32'hDEAD_0000));
    chk({tag, ".cnt"},  fetch_cnt, cnt);
  endtask

  initial begin
    reset = 1'b1; f_en = 1'b0; npc_sel = 2'd0; br_taken = 1'b0;
    d_pc = 32'h0; d_imm16 = 16'h0; d_imm26 = 26'h0; d_rs_fwd = 32'h0;

    // Reset held for two cycles
    tick(); tick();
    chk_state("reset", 32'h0000_3000, 1'b0, 32'd0);

    // Sequential fetch
    reset = 1'b0; f_en = 1'b1; npc_sel = 2'd0;
    tick(); chk_state("seq1", 32'h0000_3004, 1'b0, 32'd1);
    tick(); chk_state("seq2", 32'h0000_3008, 1'b0, 32'd2);
    tick(); chk_state("seq3", 32'h0000_300C, 1'b0, 32'd3);

    // Taken backward branch, then not-taken fall-through
    d_pc = 32'h0000_3004; d_imm16 = 16'hFFFE; npc_sel = 2'd1; br_taken = 1'b1;
    tick(); chk_state("br_taken", 32'h0000_3000, 1'b0, 32'd4);
    br_taken = 1'b0;
    tick(); chk_state("br_not", 32'h0000_3004, 1'b0, 32'd5);

    // Stall with a pending jump, then release
    f_en = 1'b0; npc_sel = 2'd2; d_imm26 = 26'h0000C10;
    tick(); chk_state("stall1", 32'h0000_3004, 1'b0, 32'd5);
    tick(); chk_state("stall2", 32'h0000_3004, 1'b0, 32'd5);
    f_en = 1'b1;
    tick(); chk_state("jump", 32'h0000_3040, 1'b0, 32'd6);

    // Register jumps: misaligned, out of range, and window edges
    npc_sel = 2'd3; d_rs_fwd = 32'h0000_3002;
    tick(); chk_state("jr_mis", 32'h0000_3002, 1'b1, 32'd7);
    d_rs_fwd = 32'h0000_7000;
    tick(); chk_state("jr_hi", 32'h0000_7000, 1'b1, 32'd8);
    d_rs_fwd = 32'h0000_6FFC;
    tick(); chk_state("jr_last", 32'h0000_6FFC, 1'b0, 32'd9);
    d_rs_fwd = 32'h0000_2FFC;
    tick(); chk_state("jr_lo", 32'h0000_2FFC, 1'b1, 32'd10);
    // Erroneous PC still advances sequentially
    npc_sel = 2'd0;
    tick(); chk_state("adv_err", 32'h0000_3000, 1'b0, 32'd11);

    // Reset during a stall with a taken branch presented
    f_en = 1'b0; npc_sel = 2'd1; br_taken = 1'b1; reset = 1'b1;
    tick(); chk_state("rst_stall", 32'h0000_3000, 1'b0, 32'd0);

    // Counter wrap
    reset = 1'b0; f_en = 1'b1; npc_sel = 2'd0; br_taken = 1'b0;
    force dut.fetch_cnt_r = 32'hFFFF_FFFF;
    #1;
    release dut.fetch_cnt_r;
    chk("cnt_forced", fetch_cnt, 32'hFFFF_FFFF);
    tick(); chk_state("cnt_wrap", 32'h0000_3004, 1'b0, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
